// File: rtl/ps2_scancode_receiver_pkg.sv
// rtl/ps2_scancode_receiver_pkg.sv - shared PS/2 frame constants, widths and types
package ps2_pkg;

   localparam int PS2_FRAME_BITS = 11;
   localparam int START_IDX      = 0;
   localparam int PAR_IDX        = 9;
   localparam int STOP_IDX       = 10;

   localparam logic [7:0] BREAK_PREFIX = 8'hF0;
   localparam logic [7:0] EXT_PREFIX   = 8'hE0;

   localparam int DEF_FIFO_DEPTH     = 8;
   localparam int DEF_TIMEOUT_CYCLES = 50000;

   // Width of a counter/pointer spanning 0..n-1, never narrower than one bit.
   function automatic int width_of(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int FIFO_PTR_W = width_of(DEF_FIFO_DEPTH);
   localparam int FIFO_CNT_W = width_of(DEF_FIFO_DEPTH + 1);
   localparam int TMO_W      = width_of(DEF_TIMEOUT_CYCLES);

   typedef enum logic {
      ST_IDLE,
      ST_RECV
   } rx_state_t;

endpackage

// File: rtl/ps2_scancode_receiver_if.sv
// rtl/ps2_scancode_receiver_if.sv - valid/ready scancode byte stream
interface ps2_scancode_receiver_if;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       scan_ready;

   modport master (output scan_code, output scan_valid, input scan_ready);
   modport slave  (input scan_code, input scan_valid, output scan_ready);
endinterface

// File: rtl/ps2_scancode_receiver_sync_fifo.sv
// rtl/ps2_scancode_receiver_sync_fifo.sv - register-based FIFO, valid/ready pop, push with accept flag
module sync_fifo
   import ps2_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             push_accept,
   output logic [WIDTH-1:0] pop_data,
   output logic             pop_valid,
   input  logic             pop_ready
);
   localparam int PTR_W = width_of(DEPTH);
   localparam int CNT_W = width_of(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             pop;

   assign pop_valid   = (count != '0);
   assign pop         = pop_valid && pop_ready;
   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign push_accept = push && ((count < CNT_W'(DEPTH)) || pop);
   assign pop_data    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_accept) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push_accept && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push_accept) begin
            count <= count - CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/ps2_scancode_receiver.sv
// rtl/ps2_scancode_receiver.sv - PS/2 device-to-host deserialiser with frame checks and byte FIFO
module ps2_scancode_receiver
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
   parameter int SYNC_STAGES    = 3,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ps2_clk,
   input  logic                      ps2_data,
   ps2_scancode_receiver_if.master   scan,
   output logic                      overflow,
   output logic                      parity_err
);
   localparam int TW = width_of(TIMEOUT_CYCLES);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic                   fall;
   logic                   bit_in;

   rx_state_t              state;
   logic [3:0]             bit_cnt;
   logic [PAR_IDX:0]       frame;
   logic [TW-1:0]          tmo;

   logic                   frame_done;
   logic                   frame_good;
   logic                   push_accept;

   // Synchronisers idle high so reset never fabricates a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign fall   = clk_prev && !clk_sync[SYNC_STAGES-1];
   assign bit_in = data_sync[SYNC_STAGES-1];

   // The stop bit is judged live from bit_in; it is never stored.
   assign frame_done = fall && (state == ST_RECV) && (bit_cnt == 4'(STOP_IDX));
   assign frame_good = frame_done && !frame[START_IDX] && bit_in && (^frame[PAR_IDX:1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         frame      <= '0;
         tmo        <= '0;
         overflow   <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         overflow   <= frame_good && !push_accept;
         parity_err <= frame_done && !frame_good;
         case (state)
            ST_IDLE: begin
               tmo <= '0;
               if (fall) begin
                  frame[START_IDX] <= bit_in;
                  bit_cnt          <= 4'd1;
                  state            <= ST_RECV;
               end
            end
            ST_RECV: begin
               if (fall) begin
                  tmo <= '0;
                  if (bit_cnt == 4'(STOP_IDX)) begin
                     bit_cnt <= '0;
                     state   <= ST_IDLE;
                  end else begin
                     frame[bit_cnt] <= bit_in;
                     bit_cnt        <= bit_cnt + 4'd1;
                  end
               end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                  tmo     <= '0;
                  bit_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  tmo <= tmo + TW'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               bit_cnt <= '0;
               tmo     <= '0;
            end
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (frame_good),
      .push_data   (frame[8:1]),
      .push_accept (push_accept),
      .pop_data    (scan.scan_code),
      .pop_valid   (scan.scan_valid),
      .pop_ready   (scan.scan_ready)
   );
endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// tb/tb_ps2_scancode_receiver.sv - directed self-checking bench for ps2_scancode_receiver
module tb_ps2_scancode_receiver;
   import ps2_pkg::*;

   localparam int H   = 20;
   localparam int TMO = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;
   logic overflow;
   logic parity_err;

   ps2_scancode_receiver_if scan_if ();

   ps2_scancode_receiver #(
      .FIFO_DEPTH     (8),
      .SYNC_STAGES    (3),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .scan       (scan_if.master),
      .overflow   (overflow),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] got[$];
   int pop_cyc[$];
   int perr_cnt, ovf_cnt, both_cnt, first_valid, stop_cyc;

   always @(negedge clk) begin
      if (!rst) begin
         if (scan_if.scan_valid && scan_if.scan_ready) begin
            got.push_back(scan_if.scan_code);
            pop_cyc.push_back(cyc);
         end
         if (parity_err) perr_cnt++;
         if (overflow) ovf_cnt++;
         if (parity_err && overflow) both_cnt++;
         if (scan_if.scan_valid && first_valid < 0) first_valid = cyc;
      end
   end

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got.delete();
      pop_cyc.delete();
      perr_cnt    = 0;
      ovf_cnt     = 0;
      first_valid = -1;
   endtask

   task automatic ps2_bit(input logic b, input bit is_stop, input bit ready_at_edge);
      ps2_data = b;
      tick(H);
      ps2_clk = 1'b0;
      if (is_stop) stop_cyc = cyc;
      if (ready_at_edge) begin
         tick(3);
         scan_if.scan_ready = 1'b1;
         tick(H - 3);
      end else begin
         tick(H);
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par = 0,
                             input bit bad_stop = 0, input bit ready_at_stop = 0);
      logic par;
      par = (~^d) ^ bad_par;
      ps2_bit(1'b0, 0, 0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i], 0, 0);
      ps2_bit(par, 0, 0);
      ps2_bit(!bad_stop, 1, ready_at_stop);
      ps2_data = 1'b1;
      tick(H);
   endtask

   function automatic int head(input int idx);
      return (got.size() > idx) ? int'(got[idx]) : -1;
   endfunction

   initial begin
      both_cnt = 0;
      clear_mon();
      scan_if.scan_ready = 1'b1;
      tick(3);
      check("rst_scan_valid", scan_if.scan_valid, 0);
      check("rst_scan_code", scan_if.scan_code, 0);
      check("rst_overflow", overflow, 0);
      check("rst_parity_err", parity_err, 0);
      rst = 1'b0;
      tick(5);

      clear_mon();
      send_frame(8'h1C);
      check("good_count", got.size(), 1);
      check("good_byte", head(0), 'h1C);
      check("good_latency", first_valid - stop_cyc, 4);
      check("good_perr", perr_cnt, 0);
      check("good_ovf", ovf_cnt, 0);
      check("good_valid_after", scan_if.scan_valid, 0);

      clear_mon();
      send_frame(8'h1C, 1, 0);
      check("badpar_count", got.size(), 0);
      check("badpar_perr", perr_cnt, 1);
      clear_mon();
      send_frame(8'h1C, 0, 1);
      check("badstop_count", got.size(), 0);
      check("badstop_perr", perr_cnt, 1);

      scan_if.scan_ready = 1'b0;
      clear_mon();
      for (int i = 1; i <= 8; i++) send_frame(8'(i));
      check("full_valid", scan_if.scan_valid, 1);
      check("full_no_ovf", ovf_cnt, 0);
      send_frame(8'h09);
      check("ovf_pulse", ovf_cnt, 1);
      check("ovf_perr", perr_cnt, 0);
      scan_if.scan_ready = 1'b1;
      tick(12);
      check("drain_count", got.size(), 8);
      for (int i = 0; i < 8; i++) check($sformatf("drain_byte%0d", i), head(i), i + 1);
      if (pop_cyc.size() == 8) check("drain_back_to_back", pop_cyc[7] - pop_cyc[0], 7);
      else check("drain_back_to_back", pop_cyc.size(), 8);
      check("drain_empty", scan_if.scan_valid, 0);

      scan_if.scan_ready = 1'b0;
      clear_mon();
      for (int i = 1; i <= 8; i++) send_frame(8'(i));
      send_frame(8'h09, 0, 0, 1);
      tick(12);
      check("coinc_no_ovf", ovf_cnt, 0);
      check("coinc_count", got.size(), 9);
      check("coinc_pop_cycle", pop_cyc.size() > 0 ? pop_cyc[0] - stop_cyc : -1, 3);
      for (int i = 0; i < 9; i++) check($sformatf("coinc_byte%0d", i), head(i), i + 1);

      clear_mon();
      ps2_bit(1'b0, 0, 0);
      ps2_bit(1'b1, 0, 0);
      ps2_bit(1'b0, 0, 0);
      ps2_bit(1'b1, 0, 0);
      ps2_bit(1'b1, 0, 0);
      ps2_data = 1'b1;
      tick(TMO + 200);
      send_frame(BREAK_PREFIX);
      check("tmo_count", got.size(), 1);
      check("tmo_byte", head(0), 'hF0);
      check("tmo_perr", perr_cnt, 0);
      check("tmo_ovf", ovf_cnt, 0);

      scan_if.scan_ready = 1'b0;
      clear_mon();
      send_frame(8'h11);
      send_frame(8'h22);
      send_frame(8'h33);
      check("pre_rst_valid", scan_if.scan_valid, 1);
      ps2_bit(1'b0, 0, 0);
      ps2_bit(1'b1, 0, 0);
      ps2_bit(1'b0, 0, 0);
      rst = 1'b1;
      tick(1);
      check("mid_rst_valid", scan_if.scan_valid, 0);
      rst = 1'b0;
      ps2_data = 1'b1;
      tick(5);
      clear_mon();
      scan_if.scan_ready = 1'b1;
      send_frame(8'h2A);
      check("post_rst_count", got.size(), 1);
      check("post_rst_byte", head(0), 'h2A);
      check("post_rst_perr", perr_cnt, 0);

      check("never_both", both_cnt, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
